// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: builds byte-enabled word accesses for the data cache,
// flags AdEL/AdES, holds a load across a cache read stall and registers the MEM/WB result.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        data_en,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wen,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        dcache_stall,
    output logic        lsu_stall,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic        wb_adel,
    output logic        wb_ades,
    output logic [31:0] wb_badvaddr
);

    typedef enum logic {S_IDLE = 1'b0, S_RD_WAIT = 1'b1} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_req_addr;
    logic [1:0]  r_req_size;
    logic        r_req_unsigned;

    logic        w_op, w_fault, w_accept, w_latch;
    logic        w_wb_valid, w_wb_adel, w_wb_ades;
    logic [31:0] w_wb_rdata, w_wb_badvaddr;

    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
    endfunction

    function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    return {4{wdata[7:0]}};
            2'd1:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    return {{24{~uns & b[7]}}, b};
            2'd1:    return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Faults only matter for live ops; a faulted op never reaches the cache.
    assign w_op     = mem_valid & (mem_read | mem_write) & ~flush;
    assign w_fault  = w_op & f_misaligned(mem_size, mem_addr[1:0]);
    assign w_accept = w_op & (mem_size != 2'd3) & ~w_fault;
    assign w_latch  = (r_state == S_IDLE) & w_accept & mem_read & dcache_stall;

    always_comb begin
        w_next        = r_state;
        data_en       = 1'b0;
        data_addr     = 32'd0;
        data_wen      = 4'b0000;
        data_wdata    = 32'd0;
        lsu_stall     = dcache_stall;
        w_wb_valid    = 1'b0;
        w_wb_rdata    = 32'd0;
        w_wb_adel     = 1'b0;
        w_wb_ades     = 1'b0;
        w_wb_badvaddr = 32'd0;
        case (r_state)
            S_IDLE: begin
                data_en    = w_accept;
                data_addr  = {mem_addr[31:2], 2'b00};
                data_wdata = f_store_data(mem_size, mem_wdata);
                if (w_accept && mem_write)
                    data_wen = f_byte_en(mem_size, mem_addr[1:0]);
                if (w_latch)
                    w_next = S_RD_WAIT;
                // A stalled cycle leaves a bubble in MEM/WB.
                if (!dcache_stall) begin
                    w_wb_valid    = mem_valid & ~flush;
                    w_wb_adel     = w_fault & mem_read;
                    w_wb_ades     = w_fault & mem_write;
                    w_wb_badvaddr = w_fault ? mem_addr : 32'd0;
                    if (w_accept && mem_read)
                        w_wb_rdata = f_load_ext(data_rdata, mem_size, mem_unsigned, mem_addr[1:0]);
                end
            end
            S_RD_WAIT: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    data_en   = 1'b1;
                    data_addr = {r_req_addr[31:2], 2'b00};
                    if (!dcache_stall) begin
                        w_next     = S_IDLE;
                        w_wb_valid = 1'b1;
                        w_wb_rdata = f_load_ext(data_rdata, r_req_size, r_req_unsigned,
                                                r_req_addr[1:0]);
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_req_addr     <= 32'd0;
            r_req_size     <= 2'd0;
            r_req_unsigned <= 1'b0;
            wb_valid       <= 1'b0;
            wb_rdata       <= 32'd0;
            wb_adel        <= 1'b0;
            wb_ades        <= 1'b0;
            wb_badvaddr    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_req_addr     <= mem_addr;
                r_req_size     <= mem_size;
                r_req_unsigned <= mem_unsigned;
            end
            wb_valid    <= w_wb_valid;
            wb_rdata    <= w_wb_rdata;
            wb_adel     <= w_wb_adel;
            wb_ades     <= w_wb_ades;
            wb_badvaddr <= w_wb_badvaddr;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues ops and queues expected MEM/WB
// entries from an arithmetic reference model; a monitor pops and compares on every wb_valid.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_read, mem_write, mem_unsigned, flush;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        data_en;
    logic [31:0] data_addr;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        dcache_stall;
    logic        lsu_stall;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        wb_adel, wb_ades;
    logic [31:0] wb_badvaddr;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .flush(flush),
        .data_en(data_en), .data_addr(data_addr), .data_wen(data_wen),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .dcache_stall(dcache_stall),
        .lsu_stall(lsu_stall),
        .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_adel(wb_adel), .wb_ades(wb_ades),
        .wb_badvaddr(wb_badvaddr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic [31:0] badv;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    int      n_checks = 0;
    int      n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference model: plain arithmetic on the architectural rules.
    function automatic bit ref_misaligned(input int size, input logic [31:0] addr);
        return (size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_ben(input int size, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (size == 0) return 32'(1 << off);
        if (size == 1) return (off >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] wd);
        longint w;
        w = longint'(wd);
        if (size == 0) return 32'((w % 256) * 64'h01010101);
        if (size == 1) return 32'((w % 65536) * 64'h00010001);
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int size, input bit uns,
                                             input logic [31:0] addr);
        longint w, v;
        int     off;
        w   = longint'(word);
        off = int'(addr % 4);
        if (size == 0) begin
            v = (w / (longint'(1) << (8 * off))) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = (w / ((off >= 2) ? 65536 : 1)) % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v[31:0];
    endfunction

    // Monitor: sampled 2ns after the edge so it sees this edge's MEM/WB write.
    always @(posedge clk) begin
        #2;
        if (rst === 1'b1 && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got wb_valid=1 rdata=%h, expected no entry (t=%0t)",
                         wb_rdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_rdata", wb_rdata, mon_e.rdata);
                check("wb_adel", 32'(wb_adel), 32'(mon_e.adel));
                check("wb_ades", 32'(wb_ades), 32'(mon_e.ades));
                check("wb_badvaddr", wb_badvaddr, mon_e.badv);
            end
        end
    end

    task automatic op(input bit valid, input bit rd, input bit wr, input int size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                      input int stall, input bit fl_issue, input bit fl_wait);
        bit      live, fault, acc, ld_stall, last, fl;
        wb_exp_t e;
        @(negedge clk);
        mem_valid    = valid;
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = 2'(size);
        mem_unsigned = uns;
        mem_addr     = addr;
        mem_wdata    = wd;
        flush        = fl_issue;
        live     = valid && (rd || wr) && !fl_issue;
        fault    = live && ref_misaligned(size, addr);
        acc      = live && size != 3 && !fault;
        ld_stall = acc && rd && stall > 0;
        dcache_stall = ld_stall;
        data_rdata   = ld_stall ? $urandom : word;
        #1;
        check("data_en", 32'(data_en), 32'(acc));
        check("lsu_stall", 32'(lsu_stall), 32'(ld_stall));
        if (acc) begin
            check("data_addr", data_addr, addr & ~32'h3);
            check("data_wen", 32'(data_wen), wr ? ref_ben(size, addr) : 32'd0);
            if (wr) check("data_wdata", data_wdata, ref_wdata(size, wd));
        end else begin
            check("data_wen_noacc", 32'(data_wen), 32'd0);
        end
        if (valid && !fl_issue && !(ld_stall && fl_wait)) begin
            e.rdata = (acc && rd) ? ref_load(word, size, uns, addr) : 32'd0;
            e.adel  = fault && rd;
            e.ades  = fault && wr;
            e.badv  = fault ? addr : 32'd0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (ld_stall) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("wb_valid_stalled", 32'(wb_valid), 32'd0);
                last = (i == stall - 1);
                fl   = fl_wait && (i == 0);
                // The waiting load must ignore whatever now sits on the mem_* inputs.
                mem_valid    = 1'($urandom);
                mem_read     = 1'($urandom);
                mem_write    = ~mem_read;
                mem_size     = 2'($urandom);
                mem_unsigned = 1'($urandom);
                mem_addr     = $urandom;
                mem_wdata    = $urandom;
                flush        = fl;
                dcache_stall = !last && !fl;
                data_rdata   = (last && !fl) ? word : $urandom;
                #1;
                check("data_en_wait", 32'(data_en), 32'(!fl));
                if (!fl) begin
                    check("data_addr_wait", data_addr, addr & ~32'h3);
                    check("data_wen_wait", 32'(data_wen), 32'd0);
                end
                check("lsu_stall_wait", 32'(lsu_stall), 32'(dcache_stall));
                @(posedge clk);
                if (fl) break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_valid    = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            flush        = 1'b0;
            dcache_stall = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit          r_valid, r_rd, r_wr, r_uns, r_fi, r_fw;
        int          r_size, r_stall, k;
        logic [31:0] r_addr, r_wd, r_word;

        rst          = 1'b0;
        mem_valid    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'd0;
        mem_unsigned = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        flush        = 1'b0;
        data_rdata   = 32'd0;
        dcache_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rdata", wb_rdata, 32'd0);
        check("rst_wb_adel", 32'(wb_adel), 32'd0);
        check("rst_wb_ades", 32'(wb_ades), 32'd0);
        check("rst_wb_badvaddr", wb_badvaddr, 32'd0);
        check("rst_data_en", 32'(data_en), 32'd0);
        check("rst_lsu_stall", 32'(lsu_stall), 32'd0);
        rst = 1'b1;

        // Directed cases.
        op(1, 1, 0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 0);  // LW, 1-cycle stall
        op(1, 1, 0, 0, 0, 32'h103, 32'h0, 32'h80112233, 0, 0, 0);  // LB
        op(1, 1, 0, 0, 1, 32'h103, 32'h0, 32'h80112233, 0, 0, 0);  // LBU
        op(1, 1, 0, 1, 1, 32'h102, 32'h0, 32'h80112233, 0, 0, 0);  // LHU
        op(1, 1, 0, 1, 0, 32'h102, 32'h0, 32'h80112233, 2, 0, 0);  // LH, 2-cycle stall
        op(1, 0, 1, 1, 0, 32'h206, 32'h1234ABCD, 32'h0, 0, 0, 0);  // SH
        op(1, 0, 1, 0, 0, 32'h101, 32'hCAFE00A5, 32'h0, 0, 0, 0);  // SB
        op(1, 0, 1, 2, 0, 32'h300, 32'h89ABCDEF, 32'h0, 0, 0, 0);  // SW
        op(1, 1, 0, 2, 0, 32'h102, 32'h0, 32'h11111111, 1, 0, 0);  // LW misaligned
        op(1, 0, 1, 1, 0, 32'h301, 32'h5555AAAA, 32'h0, 0, 0, 0);  // SH misaligned
        op(1, 1, 0, 3, 0, 32'h400, 32'h0, 32'h22222222, 0, 0, 0);  // illegal size
        op(1, 0, 0, 2, 0, 32'h404, 32'h0, 32'h0, 0, 0, 0);         // non-memory op
        op(1, 1, 0, 2, 0, 32'h408, 32'h0, 32'h33333333, 0, 1, 0);  // flushed at issue
        op(1, 1, 0, 2, 0, 32'h500, 32'h0, 32'h44444444, 2, 0, 1);  // flushed in RD_WAIT
        op(1, 0, 1, 2, 0, 32'h504, 32'h76543210, 32'h0, 0, 0, 0);  // SW right after
        idle(2);

        // Reset while a load waits on the cache.
        @(negedge clk);
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2;
        mem_unsigned = 1'b0; mem_addr = 32'h600; flush = 1'b0;
        dcache_stall = 1'b1; data_rdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b0; dcache_stall = 1'b0; data_rdata = 32'h99999999;
        @(posedge clk);
        #2;
        check("rstw_wb_valid", 32'(wb_valid), 32'd0);
        check("rstw_wb_rdata", wb_rdata, 32'd0);
        check("rstw_wb_adel", 32'(wb_adel), 32'd0);
        check("rstw_wb_ades", 32'(wb_ades), 32'd0);
        check("rstw_wb_badvaddr", wb_badvaddr, 32'd0);
        check("rstw_data_en", 32'(data_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        op(1, 1, 0, 2, 0, 32'h608, 32'h0, 32'h0BADF00D, 1, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r_valid = ($urandom % 10) != 0;
            k       = int'($urandom % 8);
            r_rd    = (k >= 1 && k <= 4);
            r_wr    = (k >= 5);
            r_size  = (($urandom % 8) == 0) ? 3 : int'($urandom % 3);
            r_uns   = 1'($urandom);
            r_addr  = $urandom;
            r_wd    = $urandom;
            r_word  = $urandom;
            r_stall = int'($urandom % 4);
            r_fi    = ($urandom % 20) == 0;
            r_fw    = ($urandom % 8) == 0;
            op(r_valid, r_rd, r_wr, r_size, r_uns, r_addr, r_wd, r_word, r_stall, r_fi, r_fw);
        end

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
